line_rasterizer: RTL

LINE_RASTERIZER -- requirements
Module: line_rasterizer

---
 rtl/vpu_pkg.sv | 29 ++
 rtl/line_rasterizer_if.sv | 32 +++
 rtl/line_rasterizer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vpu_pkg.sv
// Shared video-pipeline types: FSM states, screen defaults, coordinate widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_e;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int COORD_W      = 16;
  localparam int ERR_W        = 18;
  localparam int PIX_X_W      = 10;
  localparam int PIX_Y_W      = 9;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [ERR_W-1:0]   err_t;

  // |b - a| widened to the error width so the subtraction cannot overflow.
  function automatic err_t abs_diff(input coord_t a, input coord_t b);
    err_t d;
    d = {{(ERR_W-COORD_W){b[COORD_W-1]}}, b} - {{(ERR_W-COORD_W){a[COORD_W-1]}}, a};
    return (d < 0) ? -d : d;
  endfunction

endpackage

// File: rtl/line_rasterizer_if.sv
// Bundle of the line-in / pixel-out handshake signals of the rasterizer.
// Latency: none (wires only).
// Backpressure: line_valid/line_ready on input, pix_valid/pix_ready on output.
interface line_rasterizer_if;
  import vpu_pkg::*;

  coord_t               x0_in_f1;
  coord_t               y0_in_f1;
  coord_t               x1_in_f1;
  coord_t               y1_in_f1;
  logic                 line_valid;
  logic                 line_ready;
  logic [PIX_X_W-1:0]   pix_x;
  logic [PIX_Y_W-1:0]   pix_y;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 line_done;
  logic                 range_err;

  // Line source / pixel sink side.
  modport master (
    output x0_in_f1, y0_in_f1, x1_in_f1, y1_in_f1, line_valid, pix_ready,
    input  line_ready, pix_x, pix_y, pix_valid, line_done, range_err
  );

  // Rasterizer side.
  modport slave (
    input  x0_in_f1, y0_in_f1, x1_in_f1, y1_in_f1, line_valid, pix_ready,
    output line_ready, pix_x, pix_y, pix_valid, line_done, range_err
  );

endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: turns one clipped line into a stream of pixel coordinates.
// Latency: first pixel 2 cycles after acceptance, then one pixel per accepted cycle.
// Backpressure: pixel outputs hold while pix_ready=0; line_ready only while idle.
module line_rasterizer
  import vpu_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  coord_t             x0_in_f1,
  input  coord_t             y0_in_f1,
  input  coord_t             x1_in_f1,
  input  coord_t             y1_in_f1,
  input  logic               line_valid,
  output logic               line_ready,
  output logic [PIX_X_W-1:0] pix_x,
  output logic [PIX_Y_W-1:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               line_done,
  output logic               range_err
);

  function automatic logic out_of_range(input coord_t x, input coord_t y);
    return x[COORD_W-1] || y[COORD_W-1] || (int'(x) >= SCREEN_W) || (int'(y) >= SCREEN_H);
  endfunction

  state_e state_q, state_d;
  logic   line_ready_q, line_ready_d;
  logic   pix_valid_q, pix_valid_d;
  logic   line_done_q, line_done_d;
  logic   range_err_q, range_err_d;
  coord_t x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  coord_t cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  err_t   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic   sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  err_t   e2, err_n;
  logic   accept, line_bad, at_end;

  // line_ready is registered so it stays low throughout reset.
  assign accept   = (state_q == IDLE) && line_valid && line_ready_q;
  assign line_bad = out_of_range(x0_in_f1, y0_in_f1) || out_of_range(x1_in_f1, y1_in_f1);
  assign at_end   = (cur_x_q == x1_q) && (cur_y_q == y1_q);

  assign line_ready = line_ready_q;
  assign pix_valid  = pix_valid_q;
  assign line_done  = line_done_q;
  assign range_err  = range_err_q;
  assign pix_x      = cur_x_q[PIX_X_W-1:0];
  assign pix_y      = cur_y_q[PIX_Y_W-1:0];

  // State and datapath registers; reset abandons any line in flight.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      line_ready_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      line_done_q  <= 1'b0;
      range_err_q  <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      err_q        <= '0;
      sx_neg_q     <= 1'b0;
      sy_neg_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_ready_q <= line_ready_d;
      pix_valid_q  <= pix_valid_d;
      line_done_q  <= line_done_d;
      range_err_q  <= range_err_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      err_q        <= err_d;
      sx_neg_q     <= sx_neg_d;
      sy_neg_q     <= sy_neg_d;
    end
  end

  // Next-state: accept/reject in IDLE, derive Bresenham terms in SETUP, step in DRAW.
  always_comb begin
    state_d     = state_q;
    pix_valid_d = pix_valid_q;
    line_done_d = 1'b0;
    range_err_d = 1'b0;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    e2          = err_q <<< 1;
    err_n       = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x0_d = x0_in_f1;
          y0_d = y0_in_f1;
          x1_d = x1_in_f1;
          y1_d = y1_in_f1;
          if (line_bad) begin
            range_err_d = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        dx_d        = abs_diff(x0_q, x1_q);
        dy_d        = -abs_diff(y0_q, y1_q);
        err_d       = dx_d + dy_d;
        sx_neg_d    = (x1_q < x0_q);
        sy_neg_d    = (y1_q < y0_q);
        cur_x_d     = x0_q;
        cur_y_d     = y0_q;
        pix_valid_d = 1'b1;
        state_d     = DRAW;
      end
      DRAW: begin
        if (pix_valid_q && pix_ready) begin
          if (at_end) begin
            pix_valid_d = 1'b0;
            line_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            // Both tests use the pre-step e2, so a diagonal step applies both updates.
            if (e2 >= dy_q) begin
              err_n   = err_n + dy_q;
              cur_x_d = cur_x_q + (sx_neg_q ? -16'sd1 : 16'sd1);
            end
            if (e2 <= dx_q) begin
              err_n   = err_n + dx_q;
              cur_y_d = cur_y_q + (sy_neg_q ? -16'sd1 : 16'sd1);
            end
            err_d = err_n;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    line_ready_d = (state_d == IDLE);
  end

endmodule
